// File: rtl/fi_pkg.sv
// rtl/fi_pkg.sv - shared types and fault helper for fi_updown_counter
package fi_pkg;

  typedef enum logic [1:0] {
    FI_FLIP   = 2'd0,
    FI_SA0    = 2'd1,
    FI_SA1    = 2'd2,
    FI_NOKIND = 2'd3
  } fi_kind_e;

  typedef enum logic [1:0] {
    TGT_ENABLE = 2'd0,
    TGT_UP     = 2'd1,
    TGT_BIT    = 2'd2,
    TGT_NONE   = 2'd3
  } fi_target_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } fi_state_e;

  function automatic logic apply_fault(input logic x, input fi_kind_e kind);
    case (kind)
      FI_FLIP: return ~x;
      FI_SA0:  return 1'b0;
      FI_SA1:  return 1'b1;
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/fi_window_ctrl.sv
// rtl/fi_window_ctrl.sv - self-timed fault window FSM with delay/length counters
module fi_window_ctrl
  import fi_pkg::*;
#(
  parameter int BIT_W = 3,
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fi_arm,
  input  logic [1:0]       fi_kind,
  input  logic [1:0]       fi_target,
  input  logic [BIT_W-1:0] fi_bit,
  input  logic [DLY_W-1:0] fi_delay,
  input  logic [DLY_W-1:0] fi_len,
  output logic             fi_active,
  output logic             fi_done,
  output fi_kind_e         kind_q,
  output fi_target_e       target_q,
  output logic [BIT_W-1:0] bit_q
);

  fi_state_e        state_q, state_d;
  logic [DLY_W-1:0] dcnt, lcnt;
  logic             can_arm;

  assign can_arm = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Settings are captured only on an accepted arm so later input changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt     <= '0;
      lcnt     <= '0;
      kind_q   <= FI_NOKIND;
      target_q <= TGT_NONE;
      bit_q    <= '0;
    end else if (can_arm && fi_arm) begin
      dcnt     <= fi_delay;
      lcnt     <= fi_len;
      kind_q   <= fi_kind_e'(fi_kind);
      target_q <= fi_target_e'(fi_target);
      bit_q    <= fi_bit;
    end else if (state_q == ST_ARMED) begin
      dcnt <= dcnt - DLY_W'(1);
    end else if (state_q == ST_ACTIVE) begin
      lcnt <= lcnt - DLY_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (fi_arm) begin
          if (fi_len == '0)        state_d = ST_DONE;
          else if (fi_delay == '0) state_d = ST_ACTIVE;
          else                     state_d = ST_ARMED;
        end
      end
      ST_ARMED:  if (dcnt == DLY_W'(1)) state_d = ST_ACTIVE;
      ST_ACTIVE: if (lcnt == DLY_W'(1)) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fi_active = (state_q == ST_ACTIVE);
    fi_done   = (state_q == ST_DONE);
  end

endmodule

// File: rtl/fi_updown_counter.sv
// rtl/fi_updown_counter.sv - up/down counter with load, wrap/saturate, tc and fault injection
module fi_updown_counter
  import fi_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DLY_W = 16,
  localparam int BIT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             fi_arm,
  input  logic [1:0]       fi_kind,
  input  logic [1:0]       fi_target,
  input  logic [BIT_W-1:0] fi_bit,
  input  logic [DLY_W-1:0] fi_delay,
  input  logic [DLY_W-1:0] fi_len,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             fi_active,
  output logic             fi_done
);

  fi_kind_e         kind_q;
  fi_target_e       target_q;
  logic [BIT_W-1:0] bit_q;
  logic [WIDTH-1:0] count_q;
  logic             en_eff, up_eff, at_bnd;

  fi_window_ctrl #(.BIT_W(BIT_W), .DLY_W(DLY_W)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .fi_arm    (fi_arm),
    .fi_kind   (fi_kind),
    .fi_target (fi_target),
    .fi_bit    (fi_bit),
    .fi_delay  (fi_delay),
    .fi_len    (fi_len),
    .fi_active (fi_active),
    .fi_done   (fi_done),
    .kind_q    (kind_q),
    .target_q  (target_q),
    .bit_q     (bit_q)
  );

  always_comb begin
    en_eff = enable;
    up_eff = up;
    if (fi_active && target_q == TGT_ENABLE) en_eff = apply_fault(enable, kind_q);
    if (fi_active && target_q == TGT_UP)     up_eff = apply_fault(up, kind_q);
  end

  assign at_bnd = up_eff ? (&count_q) : ~(|count_q);

  // Wrap falls out of the modular +/-1; saturation just holds the register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc      <= 1'b0;
    end else if (load) begin
      count_q <= load_val;
      tc      <= 1'b0;
    end else if (en_eff) begin
      tc <= at_bnd;
      if (!(sat_mode && at_bnd))
        count_q <= up_eff ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end else begin
      tc <= 1'b0;
    end
  end

  // Output-bit fault corrupts only the visible value, never the register
  always_comb begin
    count = count_q;
    if (fi_active && target_q == TGT_BIT && int'(bit_q) < WIDTH)
      count[bit_q] = apply_fault(count_q[bit_q], kind_q);
  end

endmodule

// File: tb/tb_fi_updown_counter.sv
// tb/tb_fi_updown_counter.sv - directed self-checking bench for fi_updown_counter
module tb_fi_updown_counter;

  localparam int WIDTH = 8;
  localparam int DLY_W = 16;
  localparam int BIT_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             enable, up, load, sat_mode, fi_arm;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       fi_kind, fi_target;
  logic [BIT_W-1:0] fi_bit;
  logic [DLY_W-1:0] fi_delay, fi_len;
  logic [WIDTH-1:0] count;
  logic             tc, fi_active, fi_done;

  int checks   = 0;
  int failures = 0;

  int t3_cnt[9] = '{1, 2, 3, 4, 4, 4, 4, 4, 5};
  int t3_act[9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
  int t3_don[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

  fi_updown_counter #(.WIDTH(WIDTH), .DLY_W(DLY_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .sat_mode  (sat_mode),
    .fi_arm    (fi_arm),
    .fi_kind   (fi_kind),
    .fi_target (fi_target),
    .fi_bit    (fi_bit),
    .fi_delay  (fi_delay),
    .fi_len    (fi_len),
    .count     (count),
    .tc        (tc),
    .fi_active (fi_active),
    .fi_done   (fi_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    sat_mode = 1'b0; fi_arm = 1'b0; fi_kind = 2'd3; fi_target = 2'd3;
    fi_bit = '0; fi_delay = '0; fi_len = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_tc", 32'(tc), 32'h0);
    chk("rst_active", 32'(fi_active), 32'h0);
    chk("rst_done", 32'(fi_done), 32'h0);

    // wrap up through all-ones
    load = 1'b1; load_val = 8'hFE; step();
    chk("t1_load", 32'(count), 32'hFE);
    load = 1'b0; enable = 1'b1; up = 1'b1; sat_mode = 1'b0;
    step(); chk("t1_ff", 32'(count), 32'hFF); chk("t1_tc0", 32'(tc), 32'h0);
    step(); chk("t1_00", 32'(count), 32'h00); chk("t1_tc1", 32'(tc), 32'h1);
    step(); chk("t1_01", 32'(count), 32'h01); chk("t1_tc2", 32'(tc), 32'h0);

    // saturate down at zero
    enable = 1'b0; load = 1'b1; load_val = 8'h01; sat_mode = 1'b1; up = 1'b0;
    step(); chk("t2_load", 32'(count), 32'h01);
    load = 1'b0; enable = 1'b1;
    step(); chk("t2_c0", 32'(count), 32'h00); chk("t2_tc0", 32'(tc), 32'h0);
    step(); chk("t2_c1", 32'(count), 32'h00); chk("t2_tc1", 32'(tc), 32'h1);
    step(); chk("t2_c2", 32'(count), 32'h00); chk("t2_tc2", 32'(tc), 32'h1);
    enable = 1'b0;
    step(); chk("t2_tcoff", 32'(tc), 32'h0);

    // stuck-at-0 on enable, delay 3, len 4
    load = 1'b1; load_val = 8'h00; sat_mode = 1'b0;
    step();
    load = 1'b0; enable = 1'b1; up = 1'b1;
    fi_arm = 1'b1; fi_kind = 2'd1; fi_target = 2'd0; fi_delay = 16'd3; fi_len = 16'd4;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) begin
        fi_arm = 1'b0; fi_kind = 2'd0; fi_target = 2'd2; fi_bit = 3'd0;
      end
      chk($sformatf("t3_cnt%0d", i), 32'(count), 32'(t3_cnt[i]));
      chk($sformatf("t3_act%0d", i), 32'(fi_active), 32'(t3_act[i]));
      chk($sformatf("t3_don%0d", i), 32'(fi_done), 32'(t3_don[i]));
    end

    // flip output bit 7, delay 0, len 2, armed with a load of 0x10
    load = 1'b1; load_val = 8'h10;
    fi_arm = 1'b1; fi_kind = 2'd0; fi_target = 2'd2; fi_bit = 3'd7; fi_delay = 16'd0; fi_len = 16'd2;
    step(); chk("t4_90", 32'(count), 32'h90); chk("t4_act", 32'(fi_active), 32'h1);
    chk("t4_don0", 32'(fi_done), 32'h0);
    load = 1'b0; fi_arm = 1'b0;
    step(); chk("t4_91", 32'(count), 32'h91);
    step(); chk("t4_12", 32'(count), 32'h12); chk("t4_don1", 32'(fi_done), 32'h1);

    // stuck-at-1 on enable, then reset mid-window
    enable = 1'b0;
    fi_arm = 1'b1; fi_kind = 2'd2; fi_target = 2'd0; fi_delay = 16'd0; fi_len = 16'd5;
    step(); chk("t5_hold", 32'(count), 32'h12);
    fi_arm = 1'b0;
    step(); chk("t5_forced", 32'(count), 32'h13);
    reset = 1'b1;
    step(); chk("t5_rcnt", 32'(count), 32'h0); chk("t5_ract", 32'(fi_active), 32'h0);
    chk("t5_rdon", 32'(fi_done), 32'h0);
    reset = 1'b0;
    step(); chk("t5_idle", 32'(count), 32'h0); chk("t5_idle_act", 32'(fi_active), 32'h0);

    // stuck-at-0 on up, load overrides, second arm ignored
    enable = 1'b1; up = 1'b1;
    fi_arm = 1'b1; fi_kind = 2'd1; fi_target = 2'd1; fi_delay = 16'd1; fi_len = 16'd3;
    step(); chk("t6_c1", 32'(count), 32'h1);
    fi_arm = 1'b0;
    step(); chk("t6_c2", 32'(count), 32'h2); chk("t6_act", 32'(fi_active), 32'h1);
    step(); chk("t6_dn1", 32'(count), 32'h1);
    step(); chk("t6_dn0", 32'(count), 32'h0); chk("t6_tc", 32'(tc), 32'h0);
    load = 1'b1; load_val = 8'h55;
    fi_arm = 1'b1; fi_kind = 2'd0; fi_target = 2'd2; fi_delay = 16'd0; fi_len = 16'd5;
    step(); chk("t6_load", 32'(count), 32'h55); chk("t6_ltc", 32'(tc), 32'h0);
    chk("t6_rearm_act", 32'(fi_active), 32'h0); chk("t6_rearm_don", 32'(fi_done), 32'h1);
    load = 1'b0; fi_arm = 1'b0;
    step(); chk("t6_56", 32'(count), 32'h56); chk("t6_don", 32'(fi_done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
